ttc_apb_master6: RTL and testbench

//  APB (no PREADY/PSLVERR) initiator driving the timer-counter register slave.

---
 rtl/ttc_apb_master6_if.sv | 40 ++++
 rtl/ttc_apb_master6.sv | 209 ++++++++++++++++++++
 tb/tb_ttc_apb_master6.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ttc_apb_master6_if.sv
// Request, APB and response signal bundle for the timer-counter APB initiator.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface ttc_apb_master6_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32
) ();
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              req_valid6;
    logic              req_ready6;
    logic              req_write6;
    logic [ADDR_W-1:0] req_addr6;
    logic [DATA_W-1:0] req_wdata6;

    logic              psel6;
    logic              penable6;
    logic              pwrite6;
    logic [ADDR_W-1:0] paddr6;
    logic [DATA_W-1:0] pwdata6;
    logic [DATA_W-1:0] prdata6;

    logic              rsp_valid6;
    logic              rsp_write6;
    logic [DATA_W-1:0] rsp_rdata6;
    logic              busy6;
    logic [LVL_W-1:0]  fifo_level6;

    modport master (
        input  req_valid6, req_write6, req_addr6, req_wdata6, prdata6,
        output req_ready6, psel6, penable6, pwrite6, paddr6, pwdata6,
               rsp_valid6, rsp_write6, rsp_rdata6, busy6, fifo_level6
    );

    modport slave (
        output req_valid6, req_write6, req_addr6, req_wdata6, prdata6,
        input  req_ready6, psel6, penable6, pwrite6, paddr6, pwdata6,
               rsp_valid6, rsp_write6, rsp_rdata6, busy6, fifo_level6
    );
endinterface

// File: rtl/ttc_apb_master6.sv
// APB initiator (no PREADY/PSLVERR) for the timer-counter register slave.
// Requests are queued in a small command FIFO and each runs as a SETUP/ACCESS transfer.
module ttc_apb_master6 #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32
) (
    input  logic               pclk6,
    input  logic               n_p_reset6,
    ttc_apb_master6_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_write;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [LVL_W-1:0]    w_level_nxt;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_rsp_valid;
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_busy;

    logic                w_psel_nxt;
    logic                w_penable_nxt;
    logic                w_rsp_fire;
    logic                w_busy_nxt;

    // A full FIFO refuses pushes even when a pop happens on the same edge.
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == LVL_ZERO);
    assign w_push  = bus.req_valid6 && !w_full;
    assign w_pop   = !w_empty && ((r_state == S_IDLE) || (r_state == S_ACCESS));

    // Command FIFO storage
    always_ff @(posedge pclk6 or negedge n_p_reset6) begin
        if (!n_p_reset6) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= DATA_ZERO;
                r_fifo_addr[i] <= ADDR_ZERO;
            end
            r_fifo_write <= {FIFO_DEPTH{1'b0}};
        end else if (w_push) begin
            r_fifo_data[r_wr_ptr]  <= bus.req_wdata6;
            r_fifo_addr[r_wr_ptr]  <= bus.req_addr6;
            r_fifo_write[r_wr_ptr] <= bus.req_write6;
        end
    end

    // FIFO occupancy after this edge's push/pop
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // FIFO pointers and level; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge pclk6 or negedge n_p_reset6) begin
        if (!n_p_reset6) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_level  <= LVL_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level <= w_level_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge pclk6 or negedge n_p_reset6) begin
        if (!n_p_reset6) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (!w_empty) begin
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM output decode: values the output registers take on the next edge
    always_comb begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_rsp_fire    = 1'b0;
        w_busy_nxt    = 1'b0;
        case (w_state_nxt)
            S_SETUP: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b0;
            end
            S_ACCESS: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            default: begin
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
            end
        endcase
        w_rsp_fire = (r_state == S_ACCESS);
        w_busy_nxt = (w_level_nxt != LVL_ZERO) || (w_state_nxt != S_IDLE);
    end

    // APB control, address/data capture on pop, and response capture at ACCESS exit
    always_ff @(posedge pclk6 or negedge n_p_reset6) begin
        if (!n_p_reset6) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= ADDR_ZERO;
            r_pwdata    <= DATA_ZERO;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= DATA_ZERO;
            r_busy      <= 1'b0;
        end else begin
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_busy      <= w_busy_nxt;
            r_rsp_valid <= w_rsp_fire;
            if (w_pop) begin
                r_pwrite <= r_fifo_write[r_rd_ptr];
                r_paddr  <= r_fifo_addr[r_rd_ptr];
                r_pwdata <= r_fifo_write[r_rd_ptr] ? r_fifo_data[r_rd_ptr] : DATA_ZERO;
            end
            // r_pwrite still describes the finishing transfer here; a pop loads it next edge
            if (w_rsp_fire) begin
                r_rsp_write <= r_pwrite;
                r_rsp_rdata <= r_pwrite ? DATA_ZERO : bus.prdata6;
            end
        end
    end

    assign bus.req_ready6  = !w_full;
    assign bus.psel6       = r_psel;
    assign bus.penable6    = r_penable;
    assign bus.pwrite6     = r_pwrite;
    assign bus.paddr6      = r_paddr;
    assign bus.pwdata6     = r_pwdata;
    assign bus.rsp_valid6  = r_rsp_valid;
    assign bus.rsp_write6  = r_rsp_write;
    assign bus.rsp_rdata6  = r_rsp_rdata;
    assign bus.busy6       = r_busy;
    assign bus.fifo_level6 = r_level;

endmodule

// File: tb/tb_ttc_apb_master6.sv
// Randomized bench for ttc_apb_master6: a timestamp model predicts every output each cycle,
// and a few literal checks pin the latency, read data and full/reset behaviour.
module tb_ttc_apb_master6;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int DW    = 32;

    logic pclk6      = 1'b0;
    logic n_p_reset6 = 1'b0;
    always #5 pclk6 = ~pclk6;

    ttc_apb_master6_if #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ttc_apb_master6 #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .pclk6      (pclk6),
        .n_p_reset6 (n_p_reset6),
        .bus        (bus)
    );

    // Simple register-file slave: zero wait states, commits writes at the ACCESS edge
    logic [DW-1:0] smem [256];
    assign bus.prdata6 = smem[bus.paddr6];
    always @(posedge pclk6) begin
        if (n_p_reset6 && bus.psel6 && bus.penable6 && bus.pwrite6)
            smem[bus.paddr6] <= bus.pwdata6;
    end

    // One accepted request: push edge p, SETUP edge s (ACCESS after s+1, response after s+2)
    typedef struct {
        int            p;
        int            s;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
    } xfer_t;

    xfer_t         q[$];
    logic [DW-1:0] mmem [256];
    int            cyc;
    int            last_s;
    int            total;
    int            bad;
    bit            chk_en;
    bit            hit_full;

    function automatic logic [DW-1:0] init_word(int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_level(int n);
        int l = 0;
        foreach (q[k]) begin
            if (q[k].p <= n) l++;
            if (q[k].s <= n) l--;
        end
        return l;
    endfunction

    // Drive inputs, take one edge, and record an accepted push in the model
    task automatic step(bit v, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
        xfer_t x;
        bus.req_valid6 = v;
        bus.req_write6 = w;
        bus.req_addr6  = a;
        bus.req_wdata6 = d;
        @(posedge pclk6);
        #1;
        cyc++;
        if (v && model_level(cyc - 1) < DEPTH) begin
            x.p    = cyc;
            x.s    = (cyc + 1 > last_s + 2) ? cyc + 1 : last_s + 2;
            last_s = x.s;
            x.w    = w;
            x.a    = a;
            x.d    = d;
            x.rd   = w ? 32'h0 : mmem[a];
            if (w) mmem[a] = d;
            q.push_back(x);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic rnd_step(int pct);
        step(($urandom_range(0, 99) < pct), $urandom_range(0, 1),
             8'($urandom_range(0, 15)), $urandom);
    endtask

    task automatic release_reset();
        @(posedge pclk6);
        #1;
        n_p_reset6 = 1'b1;
        q.delete();
        last_s = -100;
        cyc    = 0;
        chk_en = 1'b1;
    endtask

    // Per-cycle compare of every output against the timestamp model
    always @(negedge pclk6) begin
        int n, lvl, lx, lr;
        bit act, pen, rv;
        if (chk_en) begin
            n = cyc; lvl = 0; lx = -1; lr = -1; act = 0; pen = 0; rv = 0;
            foreach (q[k]) begin
                if (q[k].p <= n) lvl++;
                if (q[k].s <= n) begin
                    lvl--;
                    lx = k;
                end
                if (q[k].s <= n && n <= q[k].s + 1) act = 1'b1;
                if (n == q[k].s + 1) pen = 1'b1;
                if (n == q[k].s + 2) rv = 1'b1;
                if (q[k].s + 2 <= n) lr = k;
            end
            chk("fifo_level", 32'(bus.fifo_level6), 32'(lvl));
            chk("req_ready", 32'(bus.req_ready6), 32'(lvl < DEPTH));
            chk("busy", 32'(bus.busy6), 32'((lvl != 0) || act));
            chk("psel", 32'(bus.psel6), 32'(act));
            chk("penable", 32'(bus.penable6), 32'(pen));
            chk("pwrite", 32'(bus.pwrite6), (lx >= 0) ? 32'(q[lx].w) : 32'h0);
            chk("paddr", 32'(bus.paddr6), (lx >= 0) ? 32'(q[lx].a) : 32'h0);
            chk("pwdata", bus.pwdata6, (lx >= 0 && q[lx].w) ? q[lx].d : 32'h0);
            chk("rsp_valid", 32'(bus.rsp_valid6), 32'(rv));
            chk("rsp_write", 32'(bus.rsp_write6), (lr >= 0) ? 32'(q[lr].w) : 32'h0);
            chk("rsp_rdata", bus.rsp_rdata6, (lr >= 0 && !q[lr].w) ? q[lr].rd : 32'h0);
        end
    end

    initial begin
        total = 0; bad = 0; chk_en = 1'b0; hit_full = 1'b0; cyc = 0; last_s = -100;
        for (int i = 0; i < 256; i++) begin
            smem[i] = init_word(i);
            mmem[i] = init_word(i);
        end
        smem[8'h24] = 32'h0000_1234;
        mmem[8'h24] = 32'h0000_1234;
        bus.req_valid6 = 1'b0; bus.req_write6 = 1'b0;
        bus.req_addr6  = 8'h00; bus.req_wdata6 = 32'h0;

        #3;
        chk("reset_psel", 32'(bus.psel6), 32'h0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid6), 32'h0);
        chk("reset_ready", 32'(bus.req_ready6), 32'h1);
        chk("reset_level", 32'(bus.fifo_level6), 32'h0);
        release_reset();
        idle(2);

        // Single write: SETUP at E1, ACCESS at E2, response at E3
        step(1'b1, 1'b1, 8'h0C, 32'h21);
        idle(1);
        chk("w_e1_psel", 32'(bus.psel6), 32'h1);
        chk("w_e1_penable", 32'(bus.penable6), 32'h0);
        chk("w_e1_paddr", 32'(bus.paddr6), 32'h0C);
        chk("w_e1_pwdata", bus.pwdata6, 32'h21);
        chk("w_e1_pwrite", 32'(bus.pwrite6), 32'h1);
        idle(1);
        chk("w_e2_penable", 32'(bus.penable6), 32'h1);
        idle(1);
        chk("w_e3_rsp_valid", 32'(bus.rsp_valid6), 32'h1);
        chk("w_e3_rsp_rdata", bus.rsp_rdata6, 32'h0);
        idle(2);

        // Single read of 0x24 with write data that must not appear on pwdata6
        step(1'b1, 1'b0, 8'h24, 32'hDEAD_BEEF);
        idle(1);
        chk("r_e1_pwdata", bus.pwdata6, 32'h0);
        idle(2);
        chk("r_e3_rsp_valid", 32'(bus.rsp_valid6), 32'h1);
        chk("r_e3_rsp_write", 32'(bus.rsp_write6), 32'h0);
        chk("r_e3_rsp_rdata", bus.rsp_rdata6, 32'h0000_1234);
        idle(3);

        // One transfer in flight, then four more back-to-back pushes: level peaks at 3
        for (int i = 0; i < 5; i++) rnd_step(100);
        chk("fill_level_peak", 32'(bus.fifo_level6), 32'h3);
        chk("fill_ready", 32'(bus.req_ready6), 32'h1);
        idle(12);

        // Hold valid high until the FIFO fills
        for (int i = 0; i < 10; i++) begin
            rnd_step(100);
            if (bus.fifo_level6 == 3'd4 && !bus.req_ready6) hit_full = 1'b1;
        end
        chk("full_seen", 32'(hit_full), 32'h1);
        idle(12);

        // Reset in the middle of an ACCESS with more reads queued
        step(1'b1, 1'b0, 8'h03, 32'h0);
        step(1'b1, 1'b0, 8'h05, 32'h0);
        step(1'b1, 1'b0, 8'h07, 32'h0);
        chk("pre_reset_penable", 32'(bus.penable6), 32'h1);
        bus.req_valid6 = 1'b0;
        chk_en = 1'b0;
        #2;
        n_p_reset6 = 1'b0;
        #1;
        chk("rst_psel", 32'(bus.psel6), 32'h0);
        chk("rst_penable", 32'(bus.penable6), 32'h0);
        chk("rst_level", 32'(bus.fifo_level6), 32'h0);
        chk("rst_busy", 32'(bus.busy6), 32'h0);
        @(posedge pclk6);
        #1;
        chk("rst_no_rsp", 32'(bus.rsp_valid6), 32'h0);
        release_reset();
        step(1'b1, 1'b0, 8'h24, 32'h0);
        idle(3);
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid6), 32'h1);
        chk("post_rst_rsp_rdata", bus.rsp_rdata6, 32'h0000_1234);
        idle(2);

        // Random traffic: mixed load, then heavy load to exercise full and pointer wrap
        for (int i = 0; i < 300; i++) rnd_step(60);
        for (int i = 0; i < 200; i++) rnd_step(90);
        idle(12);
        chk("drained_busy", 32'(bus.busy6), 32'h0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
